bin7seg_hex: RTL and testbench



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/hex_seg_lut.sv | 39 +++
 rtl/bin7seg_hex.sv | 55 +++++
 tb/tb_bin7seg_hex.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the DE1 seven-segment HEX digit decoders.
//   SEG_OFF_AL    : all segments off, active-low form.
//   SEG_HEX_AL    : 16-entry hex digit table, active-low, bit order {g,f,e,d,c,b,a}.
//   seg_polarity(): converts an active-low pattern to the selected output polarity.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_OFF_AL = 7'h7F;

    // Digits 0-9, A, b, C, d, E, F. A segment is lit where its bit is 0.
    localparam logic [6:0] SEG_HEX_AL [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low patterns pass through unchanged; active-high boards get the inverse.
    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                                input logic       active_low);
        return active_low ? pattern : ~pattern;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// -----------------------------------------------------------------------------
// hex_seg_lut
// Purely combinational nibble-to-segment lookup, active-low output.
// Ports:
//   bin  in   4  binary nibble
//   seg  out  7  segment pattern {g,f,e,d,c,b,a}, lit = 0
// -----------------------------------------------------------------------------
module hex_seg_lut
    import seg7_pkg::*;
(
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every path assigns seg (default branch included), so no latch is inferred.
        case (bin)
            4'h0:    seg = SEG_HEX_AL[0];
            4'h1:    seg = SEG_HEX_AL[1];
            4'h2:    seg = SEG_HEX_AL[2];
            4'h3:    seg = SEG_HEX_AL[3];
            4'h4:    seg = SEG_HEX_AL[4];
            4'h5:    seg = SEG_HEX_AL[5];
            4'h6:    seg = SEG_HEX_AL[6];
            4'h7:    seg = SEG_HEX_AL[7];
            4'h8:    seg = SEG_HEX_AL[8];
            4'h9:    seg = SEG_HEX_AL[9];
            4'hA:    seg = SEG_HEX_AL[10];
            4'hB:    seg = SEG_HEX_AL[11];
            4'hC:    seg = SEG_HEX_AL[12];
            4'hD:    seg = SEG_HEX_AL[13];
            4'hE:    seg = SEG_HEX_AL[14];
            4'hF:    seg = SEG_HEX_AL[15];
            // Only reachable with X/Z on bin in simulation: show a dark digit.
            default: seg = SEG_OFF_AL;
        endcase
    end

endmodule

// File: rtl/bin7seg_hex.sv
// -----------------------------------------------------------------------------
// bin7seg_hex
// Registered 4-bit binary to 7-segment hex digit decoder, one per DE1 HEX digit.
// Parameters:
//   ACTIVE_LOW  1: lit segment = 0 (DE1 default); 0: lit segment = 1
// Ports:
//   CLOCK_50  in   1  system clock, rising edge
//   resetn    in   1  synchronous active-low reset, blanks the digit
//   en        in   1  1 = load LUT(bin) this edge, 0 = hold
//   blank     in   1  1 = all segments off (overrides en)
//   bin       in   4  nibble to display
//   HEX       out  7  segment drive, bit0=a ... bit6=g
// -----------------------------------------------------------------------------
module bin7seg_hex
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       en,
    input  logic       blank,
    input  logic [3:0] bin,
    output logic [6:0] HEX
);

    logic [6:0] w_lut_al;
    logic [6:0] w_off;
    logic [6:0] w_digit;
    logic [6:0] r_hex;

    hex_seg_lut u_lut (
        .bin (bin),
        .seg (w_lut_al)
    );

    // Polarity is applied before the register so HEX comes straight from a flop.
    assign w_off   = seg_polarity(SEG_OFF_AL, ACTIVE_LOW);
    assign w_digit = seg_polarity(w_lut_al, ACTIVE_LOW);

    // Priority: reset, then blank, then load; otherwise the register holds.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            r_hex <= w_off;
        end else if (blank) begin
            r_hex <= w_off;
        end else if (en) begin
            r_hex <= w_digit;
        end
    end

    assign HEX = r_hex;

endmodule

// File: tb/tb_bin7seg_hex.sv
// -----------------------------------------------------------------------------
// tb_bin7seg_hex
// Scoreboard bench for bin7seg_hex. Two instances share the inputs: one
// active-low, one active-high. A driver applies inputs on the falling edge,
// updates a reference model of which segments are lit and queues the expected
// outputs; a monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_bin7seg_hex;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic       blank;
    logic [3:0] bin;
    logic [6:0] hex_al;
    logic [6:0] hex_ah;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bin7seg_hex #(.ACTIVE_LOW(1'b1)) dut_al (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .en       (en),
        .blank    (blank),
        .bin      (bin),
        .HEX      (hex_al)
    );

    bin7seg_hex #(.ACTIVE_LOW(1'b0)) dut_ah (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .en       (en),
        .blank    (blank),
        .bin      (bin),
        .HEX      (hex_ah)
    );

    // ---------------- reference model ----------------
    // Each digit described by the names of its lit segments.
    string seg_names [16] = '{
        "abcdef", "bc",     "abdeg",   "abcdg",
        "bcfg",   "acdfg",  "acdefg",  "abc",
        "abcdefg","abcdfg", "abcefg",  "cdefg",
        "adef",   "bcdeg",  "adefg",   "aefg"
    };

    function automatic logic [6:0] lit_mask(input int digit);
        logic [6:0] m;
        string      s;
        m = '0;
        s = seg_names[digit];
        for (int i = 0; i < s.len(); i++) begin
            m[s[i] - 8'd97] = 1'b1;
        end
        return m;
    endfunction

    logic [6:0] model_lit = '0;   // segments currently lit on the display

    typedef struct {
        logic [6:0] exp_al;
        logic [6:0] exp_ah;
        string      tag;
    } exp_t;

    exp_t sb_q [$];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 7'h%02h, expected 7'h%02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the next rising edge must show.
    task automatic step(input logic rn, input logic e, input logic bl,
                        input logic [3:0] b, input string tag);
        exp_t x;
        @(negedge clk);
        resetn = rn;
        en     = e;
        blank  = bl;
        bin    = b;
        if (!rn || bl)  model_lit = '0;
        else if (e)     model_lit = lit_mask(int'(b));
        x.exp_al = ~model_lit;
        x.exp_ah = model_lit;
        x.tag    = tag;
        sb_q.push_back(x);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check({x.tag, "/al"}, hex_al, x.exp_al);
            check({x.tag, "/ah"}, hex_ah, x.exp_ah);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0;
        en     = 1'b1;
        blank  = 1'b0;
        bin    = 4'h8;

        // Reset held two cycles with a loadable digit present, then idle.
        step(1'b0, 1'b1, 1'b0, 4'h8, "reset0");
        step(1'b0, 1'b1, 1'b0, 4'h8, "reset1");
        step(1'b1, 1'b0, 1'b0, 4'h8, "post_reset_idle");
        step(1'b1, 1'b0, 1'b0, 4'h2, "post_reset_idle2");

        // Full table sweep, en held high.
        for (int d = 0; d < 16; d++) begin
            step(1'b1, 1'b1, 1'b0, 4'(d), $sformatf("sweep_%0h", d));
        end

        // Hold: load 3, then wiggle bin with en low, then reload.
        step(1'b1, 1'b1, 1'b0, 4'h3, "hold_load3");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'hC, $sformatf("hold_%0d", i));
        end
        step(1'b1, 1'b1, 1'b0, 4'hC, "hold_reloadC");

        // Blank priority.
        step(1'b1, 1'b1, 1'b1, 4'h7, "blank_over_en");
        step(1'b1, 1'b1, 1'b0, 4'h7, "unblank_7");
        step(1'b1, 1'b0, 1'b1, 4'h7, "blank_en0");
        step(1'b1, 1'b0, 1'b0, 4'h9, "hold_blanked");

        // Reset beats blank and en; reset mid-stream.
        step(1'b1, 1'b1, 1'b0, 4'h5, "mid_load5");
        step(1'b0, 1'b1, 1'b1, 4'h5, "reset_over_blank");
        step(1'b1, 1'b1, 1'b0, 4'h5, "mid_reload5");
        step(1'b0, 1'b1, 1'b0, 4'h5, "mid_reset");
        step(1'b1, 1'b1, 1'b0, 4'hA, "after_reset_A");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic rn, e, bl;
            rn = ($urandom_range(0, 15) != 0);
            bl = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 1) == 1);
            step(rn, e, bl, 4'($urandom_range(0, 15)), $sformatf("rand_%0d", i));
        end

        // Let the monitor drain the scoreboard, with a bound.
        begin
            int guard;
            guard = 0;
            while (sb_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            #2;
            n_tests++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
